// File: rtl/zorro2_autoconfig_chain.sv
// Zorro II AutoConfig engine offering NUM_BOARDS logical boards in sequence on one card.
// Returns config nibbles, latches each board's base address and decodes per-board address hits.

module zorro2_ac_hit (
  input  logic [7:0] addr_hi,
  input  logic [7:0] base,
  input  logic [2:0] size,
  input  logic       configured,
  output logic       hit
);
  logic [7:0] mask;

  // Boards are naturally aligned, so only the bits above the board size take part.
  always_comb begin
    case (size)
      3'b000:  mask = 8'h80;
      3'b001:  mask = 8'hFF;
      3'b010:  mask = 8'hFE;
      3'b011:  mask = 8'hFC;
      3'b100:  mask = 8'hF8;
      3'b101:  mask = 8'hF0;
      3'b110:  mask = 8'hE0;
      default: mask = 8'hC0;
    endcase
  end

  assign hit = configured && (((addr_hi ^ base) & mask) == 8'h00);
endmodule

module zorro2_autoconfig_chain #(
  parameter int                          NUM_BOARDS   = 2,
  parameter logic [15:0]                 MFG_ID       = 16'h07DB,
  parameter logic [7:0]                  PROD_ID_BASE = 8'd74,
  parameter logic [31:0]                 SERIAL       = 32'd421,
  parameter logic [3*NUM_BOARDS-1:0]     BOARD_SIZE   = '0,
  parameter logic [NUM_BOARDS-1:0]       BOARD_MEM    = '1,
  parameter logic [NUM_BOARDS-1:0]       BOARD_ROM    = '0,
  parameter logic [15:0]                 ROM_VECTOR   = 16'h8000
) (
  input  logic                    CLK,
  input  logic                    RESET_n,
  input  logic [23:1]             ADDR,
  input  logic                    AS_n,
  input  logic                    RW,
  input  logic [3:0]              DIN,
  input  logic                    CFGIN_n,
  input  logic                    enable,
  input  logic                    data_phase,
  output logic [3:0]              DOUT,
  output logic                    dtack,
  output logic                    CFGOUT_n,
  output logic                    ac_cycle,
  output logic [NUM_BOARDS-1:0]   configured,
  output logic [8*NUM_BOARDS-1:0] base,
  output logic [NUM_BOARDS-1:0]   hit
);
  logic [2:0]                  idx;
  logic [3:0]                  pend_lo;
  logic                        served, done, serve, chain;
  logic [NUM_BOARDS-1:0][7:0]  base_q;
  logic [2:0]                  cur_size;
  logic                        cur_mem, cur_rom;
  logic [7:0]                  prod, rg;
  logic [3:0]                  rd_nib;
  logic                        unused_addr;

  assign unused_addr = ^ADDR[15:9];

  assign done     = (32'(idx) == 32'(NUM_BOARDS));
  assign ac_cycle = (ADDR[23:16] == 8'hE8) && !CFGIN_n && !done && enable;
  assign serve    = data_phase && ac_cycle && !served;
  assign rg       = ADDR[8:1];
  assign prod     = PROD_ID_BASE + {5'b0, idx};
  assign chain    = (32'(idx) < 32'(NUM_BOARDS - 1));
  assign base     = base_q;

  always_comb begin
    cur_size = 3'b000;
    cur_mem  = 1'b0;
    cur_rom  = 1'b0;
    for (int i = 0; i < NUM_BOARDS; i++) begin
      if (idx == 3'(i)) begin
        cur_size = BOARD_SIZE[3*i +: 3];
        cur_mem  = BOARD_MEM[i];
        cur_rom  = BOARD_ROM[i];
      end
    end
  end

  // Everything past the first two registers is returned inverted on the bus.
  always_comb begin
    rd_nib = 4'hF;
    case (rg)
      8'h00:        rd_nib = {2'b11, cur_mem, cur_rom};
      8'h01:        rd_nib = {chain, cur_size};
      8'h02:        rd_nib = ~prod[7:4];
      8'h03:        rd_nib = ~prod[3:0];
      8'h04:        rd_nib = ~4'b0000;
      8'h20, 8'h21: rd_nib = 4'h0;
      default:      ;
    endcase
    for (int k = 0; k < 4; k++) begin
      if (rg == 8'h08 + 8'(k)) rd_nib = ~MFG_ID[15-4*k -: 4];
      if (rg == 8'h14 + 8'(k)) rd_nib = cur_rom ? ~ROM_VECTOR[15-4*k -: 4] : 4'hF;
    end
    for (int k = 0; k < 8; k++)
      if (rg == 8'h0C + 8'(k)) rd_nib = ~SERIAL[31-4*k -: 4];
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      DOUT       <= 4'h0;
      dtack      <= 1'b0;
      CFGOUT_n   <= 1'b1;
      configured <= '0;
      base_q     <= '0;
      idx        <= 3'd0;
      pend_lo    <= 4'h0;
      served     <= 1'b0;
    end else begin
      dtack <= serve;
      if (serve)     served <= 1'b1;
      else if (AS_n) served <= 1'b0;
      // Chain only moves between bus cycles, so the next card never sees a half-finished cycle.
      if (AS_n) CFGOUT_n <= !done;
      if (serve) begin
        if (RW) DOUT <= rd_nib;
        else begin
          case (rg)
            8'h25: pend_lo <= DIN;
            8'h24: begin
              for (int i = 0; i < NUM_BOARDS; i++) begin
                if (idx == 3'(i)) begin
                  base_q[i]     <= {DIN, pend_lo};
                  configured[i] <= 1'b1;
                end
              end
              idx <= idx + 3'd1;
            end
            8'h26:   idx <= idx + 3'd1;
            default: ;
          endcase
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_BOARDS; g++) begin : g_hit
    zorro2_ac_hit u_hit (
      .addr_hi    (ADDR[23:16]),
      .base       (base_q[g]),
      .size       (BOARD_SIZE[3*g +: 3]),
      .configured (configured[g]),
      .hit        (hit[g])
    );
  end
endmodule
